// File: rtl/truth_table_scanner.sv
// Steps a 4-input combinational candidate through all input vectors, captures
// its truth table and scores it against a latched target (matching-row count).
module truth_table_scanner #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   target,
  output logic [N_IN-1:0]      probe_out,
  input  logic                 probe_in,
  output logic                 busy,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        fitness,
  output logic                 res_valid,
  input  logic                 res_ready
);

  localparam int unsigned T  = 2**N_IN;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [T-1:0]    target_q, target_d;
  logic [T-1:0]    table_q, table_d;
  logic [N_IN:0]   fit_q, fit_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            sample;

  // The vector index doubles as the probe register: both step together and
  // the probe returns to 0 whenever the scan is not running.
  assign probe_out = idx_q;
  assign busy      = busy_q;
  assign table_out = table_q;
  assign fitness   = fit_q;
  assign res_valid = valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    sample = (state_q == SCAN) && (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (sample && (idx_q == IDX_LAST)) state_d = DONE;
      DONE:    if (valid_q && res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    target_d = target_q;
    table_d  = table_q;
    fit_d    = fit_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d = target;
          table_d  = '0;
          fit_d    = '0;
          idx_d    = '0;
          cnt_d    = '0;
        end
      end
      SCAN: begin
        if (sample) begin
          table_d[idx_q] = probe_in;
          if (probe_in == target_q[idx_q]) fit_d = fit_q + (N_IN+1)'(1);
          cnt_d = '0;
          if (idx_q == IDX_LAST) idx_d = '0;
          else                   idx_d = idx_q + N_IN'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    busy_d  = (state_d == SCAN);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      table_q  <= '0;
      fit_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      table_q  <= table_d;
      fit_q    <= fit_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: SETTLE=1 and SETTLE=3 instances, table-driven
// vectors, hand-written handshake/reset sequences and randomized candidates.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n, start1, start3, res_ready;
  logic [15:0] target;
  logic [3:0]  probe1, probe3;
  logic        pin1, pin3, busy1, busy3, valid1, valid3;
  logic [15:0] tab1, tab3;
  logic [4:0]  fit1, fit3;

  int          cand_sel;
  logic [15:0] rnd_tab;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Candidate circuits: 0 = a&b&c, 1 = constant 0, 2 = d, 3 = lookup in rt.
  function automatic logic cand(input int sel, input logic [3:0] v, input logic [15:0] rt);
    case (sel)
      0:       return v[3] & v[2] & v[1];
      1:       return 1'b0;
      2:       return v[0];
      default: return rt[v];
    endcase
  endfunction

  assign pin1 = cand(cand_sel, probe1, rnd_tab);
  assign pin3 = cand(cand_sel, probe3, rnd_tab);

  truth_table_scanner #(.N_IN(4), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .target(target),
    .probe_out(probe1), .probe_in(pin1), .busy(busy1), .table_out(tab1),
    .fitness(fit1), .res_valid(valid1), .res_ready(res_ready));

  truth_table_scanner #(.N_IN(4), .SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .target(target),
    .probe_out(probe3), .probe_in(pin3), .busy(busy3), .table_out(tab3),
    .fitness(fit3), .res_valid(valid3), .res_ready(res_ready));

  function automatic logic [3:0]  g_probe(input int w); return (w == 3) ? probe3 : probe1; endfunction
  function automatic logic        g_busy (input int w); return (w == 3) ? busy3  : busy1;  endfunction
  function automatic logic        g_valid(input int w); return (w == 3) ? valid3 : valid1; endfunction
  function automatic logic [15:0] g_tab  (input int w); return (w == 3) ? tab3   : tab1;   endfunction
  function automatic logic [4:0]  g_fit  (input int w); return (w == 3) ? fit3   : fit1;   endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 3) start3 = v; else start1 = v;
  endtask

  task automatic do_start(input int w);
    @(negedge clk);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
  endtask

  // Called one negedge after the accepting edge; counts edges until res_valid.
  task automatic wait_valid(input int w, input int pulse_at, input logic flip, output int lat);
    int s   = (w == 3) ? 3 : 1;
    int m   = 0;
    int bad = 0;
    check("start_busy", 32'(g_busy(w)), 32'd1);
    check("start_probe", 32'(g_probe(w)), 32'd0);
    while (!g_valid(w) && m < 16 * s + 20) begin
      if (g_busy(w) !== 1'b1 || g_probe(w) !== 4'(m / s)) bad++;
      if (m == pulse_at) begin
        set_start(w, 1'b1);
        if (flip) target = ~target;
      end else begin
        set_start(w, 1'b0);
      end
      @(negedge clk);
      m++;
    end
    set_start(w, 1'b0);
    lat = m;
    check("probe_seq", 32'(bad), 32'd0);
    check("latency", 32'(m), 32'(16 * s));
    check("done_busy", 32'(g_busy(w)), 32'd0);
    check("done_probe", 32'(g_probe(w)), 32'd0);
  endtask

  task automatic accept(input int w);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("ack_valid", 32'(g_valid(w)), 32'd0);
    check("ack_busy", 32'(g_busy(w)), 32'd0);
  endtask

  task automatic check_zero(input int w);
    check("rst_probe", 32'(g_probe(w)), 32'd0);
    check("rst_busy", 32'(g_busy(w)), 32'd0);
    check("rst_table", 32'(g_tab(w)), 32'd0);
    check("rst_fit", 32'(g_fit(w)), 32'd0);
    check("rst_valid", 32'(g_valid(w)), 32'd0);
  endtask

  typedef struct {
    int          w;
    int          sel;
    logic [15:0] tgt;
    logic [15:0] exp_tab;
    int          exp_fit;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          bad;
    logic [15:0] exp_tab;
    logic [15:0] tgt0;
    int          w;

    vecs[0] = '{w: 1, sel: 0, tgt: 16'hC000, exp_tab: 16'hC000, exp_fit: 16};
    vecs[1] = '{w: 1, sel: 0, tgt: 16'h3FFF, exp_tab: 16'hC000, exp_fit: 0};
    vecs[2] = '{w: 1, sel: 1, tgt: 16'h0001, exp_tab: 16'h0000, exp_fit: 15};
    vecs[3] = '{w: 3, sel: 2, tgt: 16'hAAAA, exp_tab: 16'hAAAA, exp_fit: 16};
    vecs[4] = '{w: 3, sel: 0, tgt: 16'hC001, exp_tab: 16'hC000, exp_fit: 15};
    vecs[5] = '{w: 1, sel: 2, tgt: 16'h00FF, exp_tab: 16'hAAAA, exp_fit: 8};

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; res_ready = 1'b0;
    target = '0; cand_sel = 0; rnd_tab = '0;
    repeat (2) @(negedge clk);
    check_zero(1);
    check_zero(3);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      cand_sel = vecs[k].sel;
      target   = vecs[k].tgt;
      do_start(vecs[k].w);
      wait_valid(vecs[k].w, -1, 1'b0, lat);
      check("vec_table", 32'(g_tab(vecs[k].w)), 32'(vecs[k].exp_tab));
      check("vec_fit", 32'(g_fit(vecs[k].w)), 32'(vecs[k].exp_fit));
      accept(vecs[k].w);
    end

    // Backpressure, ignored starts and mid-scan target change.
    cand_sel = 0;
    target   = 16'hC000;
    do_start(1);
    wait_valid(1, 5, 1'b1, lat);
    check("bp_table", 32'(tab1), 32'hC000);
    check("bp_fit", 32'(fit1), 32'd16);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      start1 = (k % 3 == 0);
      @(negedge clk);
      if (valid1 !== 1'b1 || busy1 !== 1'b0 || tab1 !== 16'hC000 ||
          fit1 !== 5'd16 || probe1 !== 4'd0) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    res_ready = 1'b1;
    start1    = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("hs_valid", 32'(valid1), 32'd0);
    check("hs_start_ignored", 32'(busy1), 32'd0);
    @(negedge clk);
    start1 = 1'b0;
    wait_valid(1, -1, 1'b0, lat);
    check("restart_table", 32'(tab1), 32'hC000);
    check("restart_fit", 32'(fit1), 32'd0);
    accept(1);

    // Reset while probe_out == 7.
    target = 16'hC000;
    do_start(1);
    repeat (7) @(negedge clk);
    check("pre_reset_probe", 32'(probe1), 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero(1);
    check_zero(3);
    @(negedge clk);
    check("post_reset_idle", 32'(busy1 | valid1), 32'd0);
    do_start(1);
    wait_valid(1, -1, 1'b0, lat);
    check("post_reset_table", 32'(tab1), 32'hC000);
    check("post_reset_fit", 32'(fit1), 32'd16);
    accept(1);

    // Randomized candidates against the truth-table/popcount model.
    for (int r = 0; r < 20; r++) begin
      w        = ($urandom_range(0, 3) == 0) ? 3 : 1;
      cand_sel = $urandom_range(0, 3);
      rnd_tab  = 16'($urandom);
      target   = 16'($urandom);
      tgt0     = target;
      for (int i = 0; i < 16; i++) exp_tab[i] = cand(cand_sel, 4'(i), rnd_tab);
      do_start(w);
      wait_valid(w, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lat);
      check("rnd_table", 32'(g_tab(w)), 32'(exp_tab));
      check("rnd_fit", 32'(g_fit(w)), 32'(16 - $countones(exp_tab ^ tgt0)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rnd_held", 32'(g_valid(w)), 32'd1);
      accept(w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
